// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive frame controller.
//   DATA_WIDTH_DEF / PRESCALE_WIDTH_DEF : default frame and prescale widths
//   BIT_CNT_W                           : width of the bit-in-frame counter
//   PRESCALE_RST                        : latched oversampling ratio after reset
//   state_e                             : frame controller states (binary coded)
package uart_rx_fsm_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int PRESCALE_WIDTH_DEF = 6;
  localparam int BIT_CNT_W          = 4;
  localparam int PRESCALE_RST       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the frame controller and the receive-path blocks around it.
//   master : the frame controller (consumes line/config/checker results,
//            drives counters, strobes and debug state)
//   slave  : sampler, deserializer and start/parity/stop checkers
// Handshake: there is no backpressure. Every *_en strobe and data_valid is a
// single-cycle pulse that the consumer must act on in that cycle; checker
// results (strt_glitch, par_err, stp_err) need only be valid in the cycle
// their matching *_chk_en strobe is high.
interface uart_rx_fsm_if
  import uart_rx_fsm_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) ();

  logic                      rx_in;
  logic                      par_en;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      strt_glitch;
  logic                      par_err;
  logic                      stp_err;

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic                      dat_samp_en;
  logic                      deser_en;
  logic                      strt_chk_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      data_valid;
  state_e                    state;

  modport master (
    input  rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, state
  );

  modport slave (
    output rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, state
  );

endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversampling edge counter and bit-in-frame counter.
//   clk, rst      : clock, asynchronous active-low reset
//   enable_i      : count while high, both counts cleared while low
//   p_i           : oversampling ratio (edges per bit)
//   edge_cnt_o    : edge index within current bit, 0..p_i-1
//   bit_cnt_o     : bit index within frame
//   bit_end_o     : current cycle is the last edge of a bit
//   bit_end_nxt_o : next cycle will be the last edge of a bit (lets the
//                   controller register its strobes one cycle early)
module uart_rx_fsm_edge_bit_counter
  import uart_rx_fsm_pkg::*;
#(
  parameter int PW = PRESCALE_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [PW-1:0]        p_i,
  output logic [PW-1:0]        edge_cnt_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o,
  output logic                 bit_end_o,
  output logic                 bit_end_nxt_o
);

  logic [PW-1:0]        edge_q, edge_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [PW-1:0]        last_edge;

  assign last_edge = p_i - PW'(1);
  assign bit_end_o = (edge_q == last_edge);

  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (enable_i) begin
      if (bit_end_o) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_CNT_W'(1);
      end else begin
        edge_d = edge_q + PW'(1);
        bit_d  = bit_q;
      end
    end
  end

  assign bit_end_nxt_o = enable_i && (edge_d == last_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: detects the start edge, sequences
// start / data (LSB first) / optional parity / stop, issues one-cycle
// strobes to the sampler, deserializer and checkers, and pulses data_valid
// only for a frame that passed every check.
//   clk  : receive clock
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_fsm_if master modport (line, config, checker results in;
//          counters, strobes, data_valid and debug state out)
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fsm_if.master bus
);

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] p_q;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic                      bit_end, bit_end_nxt;
  logic                      dat_samp_en_q, deser_en_q, strt_chk_en_q;
  logic                      par_chk_en_q, stp_chk_en_q, data_valid_q;

  // Counters run whenever the next state is inside a frame, so the start
  // detect cycle itself is edge 0 and START is entered with edge_cnt=1.
  uart_rx_fsm_edge_bit_counter #(.PW(PRESCALE_WIDTH)) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (state_d != IDLE),
    .p_i           (p_q),
    .edge_cnt_o    (edge_cnt),
    .bit_cnt_o     (bit_cnt),
    .bit_end_o     (bit_end),
    .bit_end_nxt_o (bit_end_nxt)
  );

  // Checker results are sampled in the bit-end cycle; an error overrides
  // the normal forward transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.rx_in) state_d = START;
      START:   if (bit_end) state_d = bus.strt_glitch ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                 state_d = bus.par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = bus.par_err ? IDLE : STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from next-cycle state and next-cycle bit end so
  // they are high exactly in the cycle edge_cnt == P-1. A state change only
  // happens on a bit end, and the following cycle has edge_cnt=0, so state_d
  // is the state that will own that bit end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      p_q           <= PRESCALE_WIDTH'(PRESCALE_RST);
      dat_samp_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      strt_chk_en_q <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Ratio is frozen for the whole frame; only IDLE cycles reload it.
      if (state_q == IDLE) p_q <= bus.prescale;
      dat_samp_en_q <= (state_d != IDLE);
      strt_chk_en_q <= bit_end_nxt && (state_d == START);
      deser_en_q    <= bit_end_nxt && (state_d == DATA);
      par_chk_en_q  <= bit_end_nxt && (state_d == PARITY);
      stp_chk_en_q  <= bit_end_nxt && (state_d == STOP);
      data_valid_q  <= (state_q == STOP) && bit_end && !bus.stp_err;
    end
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.dat_samp_en = dat_samp_en_q;
  assign bus.deser_en    = deser_en_q;
  assign bus.strt_chk_en = strt_chk_en_q;
  assign bus.par_chk_en  = par_chk_en_q;
  assign bus.stp_chk_en  = stp_chk_en_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: table of frames with hand-computed frame lengths,
// per-cycle comparison against a timing model, byte scoreboard on
// data_valid, plus back-to-back and mid-frame reset sequences.
module tb_uart_rx_fsm;
  import uart_rx_fsm_pkg::*;

  typedef struct {
    int         p;        // prescale at frame start
    int         p_mid;    // prescale driven from cycle 20 on (must be ignored)
    bit         par_en;
    logic [7:0] data;
    bit         glitch;   // rx low 3 cycles only, strt_glitch=1
    bit         perr;
    bit         serr;
    int         exp_len;  // cycle (from detect) at which IDLE is re-entered
    bit         exp_dv;   // data_valid expected in cycle exp_len
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fsm_if #(.PRESCALE_WIDTH(6)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] shift_byte;
  vec_t       vecs[8];

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, k, got, exp);
    end
  endtask

  // {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}
  function automatic logic [5:0] exp_out(input vec_t v, input int k, input bit dv0);
    int  b = k / v.p;
    bit  bend = ((k % v.p) == v.p - 1);
    bit  act = (k >= 1) && (k < v.exp_len);
    logic [5:0] r;
    r[5] = act;
    r[4] = act && bend && (b >= 1) && (b <= 8);
    r[3] = act && bend && (b == 0);
    r[2] = act && bend && v.par_en && (b == 9);
    r[1] = act && bend && (b == 9 + int'(v.par_en));
    r[0] = ((k == v.exp_len) && v.exp_dv) || ((k == 0) && dv0);
    return r;
  endfunction

  function automatic logic [9:0] exp_cnt(input vec_t v, input int k);
    bit act = (k >= 1) && (k < v.exp_len);
    if (!act) return '0;
    return {6'(k % v.p), 4'(k / v.p)};
  endfunction

  function automatic logic rx_bit(input vec_t v, input int k);
    int b = k / v.p;
    if (v.glitch) return (k < 3) ? 1'b0 : 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return v.data[b-1];
    if (b == 9 && v.par_en) return ^v.data;
    return 1'b1;
  endfunction

  task automatic check_all_zero(input string name, input int k);
    chk(name, k, {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                  bus.par_chk_en, bus.stp_chk_en, bus.data_valid,
                  bus.edge_cnt, bus.bit_cnt}, '0);
  endtask

  // ---------------- driver ----------------
  // Cycle 0 is the start-detect cycle. With chain=1 the task returns after
  // the last active cycle so the next call's cycle 0 is the data_valid cycle.
  task automatic run_vec(input vec_t v, input bit chain, input bit dv0,
                         input int abort_at);
    int n = chain ? v.exp_len : v.exp_len + 4;
    int nd = 0;
    bus.prescale    = 6'(v.p);
    bus.par_en      = v.par_en;
    bus.strt_glitch = v.glitch;
    bus.par_err     = v.perr;
    bus.stp_err     = v.serr;
    if (v.exp_dv) exp_q.push_back(v.data);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("strobes", k, {bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                         bus.par_chk_en, bus.stp_chk_en, bus.data_valid},
          exp_out(v, k, dv0));
      chk("counters", k, {bus.edge_cnt, bus.bit_cnt}, exp_cnt(v, k));
      if (bus.data_valid) begin
        if (exp_q.size() == 0) chk("dv_unexpected", k, 1, 0);
        else chk("dv_byte", k, shift_byte, exp_q.pop_front());
      end
      if (k >= 20) bus.prescale = 6'(v.p_mid);
      bus.rx_in = rx_bit(v, k);
      if (bus.deser_en) begin
        shift_byte = {bus.rx_in, shift_byte[7:1]};
        nd++;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        check_all_zero("rst_async", k);
        @(negedge clk);
        check_all_zero("rst_hold", k + 1);
        chk("rst_state", k + 1, bus.state, IDLE);
        bus.rx_in = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
    end
    chk("deser_count", n, nd, v.glitch ? 0 : 8);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t b2b1, b2b2, rvec, pvec;
    vecs[0] = '{p:8,  p_mid:8,  par_en:1'b0, data:8'hA5, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:80,  exp_dv:1'b1};
    vecs[1] = '{p:16, p_mid:16, par_en:1'b1, data:8'h96, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:176, exp_dv:1'b1};
    vecs[2] = '{p:8,  p_mid:8,  par_en:1'b0, data:8'h00, glitch:1'b1, perr:1'b0, serr:1'b0, exp_len:8,   exp_dv:1'b0};
    vecs[3] = '{p:8,  p_mid:8,  par_en:1'b1, data:8'h55, glitch:1'b0, perr:1'b1, serr:1'b0, exp_len:80,  exp_dv:1'b0};
    vecs[4] = '{p:8,  p_mid:8,  par_en:1'b1, data:8'h0F, glitch:1'b0, perr:1'b0, serr:1'b1, exp_len:88,  exp_dv:1'b0};
    vecs[5] = '{p:4,  p_mid:4,  par_en:1'b0, data:8'hFF, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:40,  exp_dv:1'b1};
    vecs[6] = '{p:62, p_mid:62, par_en:1'b1, data:8'h81, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:682, exp_dv:1'b1};
    vecs[7] = '{p:8,  p_mid:8,  par_en:1'b0, data:8'h00, glitch:1'b0, perr:1'b0, serr:1'b1, exp_len:80,  exp_dv:1'b0};
    b2b1 = '{p:8, p_mid:8,  par_en:1'b0, data:8'h3C, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:80, exp_dv:1'b1};
    b2b2 = '{p:8, p_mid:8,  par_en:1'b0, data:8'hC3, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:80, exp_dv:1'b1};
    rvec = '{p:8, p_mid:8,  par_en:1'b0, data:8'h5A, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:80, exp_dv:1'b0};
    pvec = '{p:8, p_mid:16, par_en:1'b0, data:8'h5A, glitch:1'b0, perr:1'b0, serr:1'b0, exp_len:80, exp_dv:1'b1};

    bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.prescale = 6'd8;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    shift_byte = '0;

    // reset values
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs", 0);
    chk("reset_state", 0, bus.state, IDLE);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("idle_outputs", 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0, 1'b0, -1);

    // back-to-back: second start detected in the data_valid cycle
    run_vec(b2b1, 1'b1, 1'b0, -1);
    run_vec(b2b2, 1'b0, 1'b1, -1);

    // reset during data bit 4, then a clean frame with a mid-frame
    // prescale change that must be ignored
    run_vec(rvec, 1'b0, 1'b0, 35);
    run_vec(pvec, 1'b0, 1'b0, -1);

    chk("sb_drain", 0, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
